// File: rtl/compare_arbiter_pkg.sv
// Shared types and result encodings for the compare_arbiter block.
package compare_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

endpackage

// File: rtl/compare_arbiter_cmp_core.sv
// Combinational unsigned magnitude comparator returning a one-hot gt/eq/lt result.
module cmp_core
  import compare_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_res_t         res
);

  // Full-width unsigned compare; exactly one result bit is set.
  always_comb begin
    res = cmp_res_t'(CMP_EQ);
    if (a > b) begin
      res = cmp_res_t'(CMP_GT);
    end else if (a < b) begin
      res = cmp_res_t'(CMP_LT);
    end
  end

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin arbiter sharing one registered comparator among NUM_REQ requesters.
// Optional build macro GRAY_OPERANDS_EN: operands arrive Gray-coded and are
// decoded to binary in the IDLE capture path, ahead of the operand registers.
//
// state | meaning
// IDLE  | searching for a request from rr_ptr upward; grant and capture operands
// CMP   | comparator evaluates captured operands; result registered
// RESP  | rsp_valid high, result held until rsp_ready
module compare_arbiter
  import compare_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_gt,
  output logic                     rsp_eq,
  output logic                     rsp_lt,
  output logic                     busy
);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   cur_id;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  cmp_res_t          res_q;
  cmp_res_t          cmp_out;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [WIDTH-1:0]  cap_a;
  logic [WIDTH-1:0]  cap_b;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found   = 1'b1;
        grant_idx     = ID_W'(idx);
        grant_oh[idx] = 1'b1;
      end
    end
  end

  // Accept strobe only in IDLE and never while reset is being applied.
  assign req_ready = (rst_n && state == IDLE && grant_found) ? grant_oh : '0;

  assign sel_a = req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_b = req_b[int'(grant_idx)*WIDTH +: WIDTH];

`ifdef GRAY_OPERANDS_EN
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign cap_a = gray2bin(sel_a);
  assign cap_b = gray2bin(sel_b);
`else
  assign cap_a = sel_a;
  assign cap_b = sel_b;
`endif

  cmp_core #(.WIDTH(WIDTH)) u_cmp_core (
    .a   (op_a),
    .b   (op_b),
    .res (cmp_out)
  );

  // Control FSM with operand, id and result registers; reset drops any pending result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cur_id      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      res_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a   <= cap_a;
            op_b   <= cap_b;
            cur_id <= grant_idx;
            state  <= CMP;
          end
        end
        CMP: begin
          res_q       <= cmp_out;
          rsp_id_q    <= cur_id;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            res_q       <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rr_ptr      <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_gt    = res_q.gt;
  assign rsp_eq    = res_q.eq;
  assign rsp_lt    = res_q.lt;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_compare_arbiter.sv
// Directed self-checking bench for compare_arbiter.
module tb_compare_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int IW = 2;
  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic           rsp_gt;
  logic           rsp_eq;
  logic           rsp_lt;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  compare_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .rsp_eq    (rsp_eq),
    .rsp_lt    (rsp_lt),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
  endtask

  // One isolated request from an idle FSM with rsp_ready=1; checks grant, latency and result.
  task automatic do_single(input string tag, input int id, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2:0] exp_res);
    @(negedge clk);
    set_ops(id, a, b);
    req_valid = N'(1) << id;
    rsp_ready = 1'b1;
    #1;
    check({tag, "_ready"}, req_ready, N'(1) << id);
    @(negedge clk);
    req_valid = '0;
    #1;
    check({tag, "_cmp_valid"}, rsp_valid, 1'b0);
    check({tag, "_cmp_busy"}, busy, 1'b1);
    @(negedge clk);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_rsp_id"}, rsp_id, id);
    check({tag, "_rsp_res"}, {rsp_gt, rsp_eq, rsp_lt}, exp_res);
    @(negedge clk);
    check({tag, "_done_valid"}, rsp_valid, 1'b0);
    check({tag, "_done_busy"}, busy, 1'b0);
    check({tag, "_done_res"}, {rsp_gt, rsp_eq, rsp_lt}, 3'b000);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset held with all requests pending: nothing may be granted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", req_ready, 4'b0000);
      check("rst_valid", rsp_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
    end
    req_valid = '0;
    rst_n     = 1'b1;

    // Single request on requester 2.
    do_single("single", 2, 4'd9, 4'd3, R_GT);

    // Reset again so the round-robin pointer starts at 0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // All four valid with equal operands: service order 0,1,2,3 then wrap to 0.
    for (int k = 0; k < N; k++) set_ops(k, 4'd5, 4'd5);
    req_valid = '1;
    for (int k = 0; k < N; k++) begin
      #1;
      check("rr_ready", req_ready, N'(1) << k);
      @(negedge clk);
      check("rr_cmp_ready", req_ready, 4'b0000);
      @(negedge clk);
      check("rr_id", rsp_id, k);
      check("rr_res", {rsp_gt, rsp_eq, rsp_lt}, R_EQ);
      check("rr_resp_ready", req_ready, 4'b0000);
      @(negedge clk);
    end
    #1;
    check("rr_wrap", req_ready, 4'b0001);
    req_valid = '0;

    // Backpressure on requester 1 (pointer at 0, so requester 1 wins).
    @(negedge clk);
    rsp_ready = 1'b0;
    set_ops(1, 4'd1, 4'd14);
    req_valid = 4'b0010;
    #1;
    check("bp_ready", req_ready, 4'b0010);
    @(negedge clk);
    set_ops(0, 4'd2, 4'd2);
    set_ops(2, 4'd7, 4'd7);
    set_ops(3, 4'd0, 4'd0);
    req_valid = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_id", rsp_id, 2'd1);
      check("bp_res", {rsp_gt, rsp_eq, rsp_lt}, R_LT);
      check("bp_no_ready", req_ready, 4'b0000);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_released", rsp_valid, 1'b0);
    // Requests raised during CMP/RESP were kept; pointer is now 2.
    check("bp_next_grant", req_ready, 4'b0100);

    // Reset while a result is pending in RESP.
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("rst_resp_pending", rsp_valid, 1'b1);
    check("rst_resp_id", rsp_id, 2'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", rsp_valid, 1'b0);
    check("rst_resp_busy", busy, 1'b0);
    check("rst_resp_res", {rsp_gt, rsp_eq, rsp_lt}, 3'b000);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    set_ops(0, 4'd3, 4'd10);
    req_valid = '1;
    #1;
    check("rst_resp_ptr0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    check("rst_resp_cmp", rsp_valid, 1'b0);
    @(negedge clk);
    check("rst_resp_new_id", rsp_id, 2'd0);
    check("rst_resp_new_res", {rsp_gt, rsp_eq, rsp_lt}, R_LT);
    @(negedge clk);
    check("rst_resp_idle", busy, 1'b0);

    // Operand coding vectors (pointer is now 1, requester 3 alone always wins).
`ifdef GRAY_OPERANDS_EN
    do_single("code_8_4", 3, 4'b1000, 4'b0100, R_GT);
    do_single("code_6_7", 3, 4'b0110, 4'b0111, R_LT);
    do_single("code_8_12", 3, 4'b1000, 4'b1100, R_GT);
    do_single("code_f_0", 3, 4'b1111, 4'b0000, R_GT);
    do_single("code_0_f", 3, 4'b0000, 4'b1111, R_LT);
`else
    do_single("code_8_4", 3, 4'b1000, 4'b0100, R_GT);
    do_single("code_6_7", 3, 4'b0110, 4'b0111, R_LT);
    do_single("code_8_12", 3, 4'b1000, 4'b1100, R_LT);
    do_single("code_f_0", 3, 4'b1111, 4'b0000, R_GT);
    do_single("code_0_f", 3, 4'b0000, 4'b1111, R_LT);
`endif
    do_single("code_eq", 3, 4'b1010, 4'b1010, R_EQ);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
